// File: rtl/sugar_ledger_if.sv
// ---------------------------------------------------------------------------
// sugar_ledger_if
//   Single-port sugar map RAM bus between the sugar ledger (master) and the
//   sugar map RAM (slave).
//
//   Parameters:
//     AW : RAM address width ({Y,X})
//     DW : sugar bits per map cell
//
//   Signals:
//     mem_addr   master->slave  AW  cell address {Y,X}
//     mem_rd     master->slave  1   read strobe, data on mem_rdata next cycle
//     mem_rdata  slave->master  DW  read data
//     mem_wr     master->slave  1   write strobe
//     mem_wdata  master->slave  DW  write data
// ---------------------------------------------------------------------------
interface sugar_ledger_if #(
  parameter int AW = 8,
  parameter int DW = 4
) ();
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/sugar_ledger.sv
// ---------------------------------------------------------------------------
// sugar_ledger
//   Once per game tick, snapshots every ant's collect/drop flags and X/Y,
//   then walks the ants in index order through one single-port RAM port:
//   collecting ants decrement their cell in the sugar map (read, wait,
//   write back value-1), dropping ants bump the colony food tally.
//
//   Optional feature (macro SUGAR_LEDGER_OVERRUN_EN):
//     adds overrun_cnt, a saturating count of update_flag strobes that
//     arrive while a scan is still running (including its FIN cycle).
//     Without the macro those strobes are silently dropped.
//
//   Ports:
//     game_clk     clock
//     RESET        asynchronous, active-high reset
//     update_flag  game-tick strobe
//     collect_vec  per-ant collecting_sugar
//     drop_vec     per-ant dropping_sugar
//     ant_X/ant_Y  packed coordinates, ant i at [i*W +: W]
//     mem          sugar map RAM bus (master side)
//     food_count   sugar delivered to the colony (saturating)
//     empty_picks  collects that found an empty cell (saturating at 255)
//     busy         scan in progress
//     done         one-cycle pulse as a scan completes
//     overrun_cnt  (SUGAR_LEDGER_OVERRUN_EN only) ignored strobes
// ---------------------------------------------------------------------------
module sugar_ledger #(
  parameter int N_ANTS  = 8,
  parameter int XW      = 4,
  parameter int YW      = 4,
  parameter int SUGAR_W = 4,
  parameter int FOOD_W  = 16
) (
  input  logic                 game_clk,
  input  logic                 RESET,
  input  logic                 update_flag,
  input  logic [N_ANTS-1:0]    collect_vec,
  input  logic [N_ANTS-1:0]    drop_vec,
  input  logic [N_ANTS*XW-1:0] ant_X,
  input  logic [N_ANTS*YW-1:0] ant_Y,
  sugar_ledger_if.master       mem,
  output logic [FOOD_W-1:0]    food_count,
  output logic [7:0]           empty_picks,
  output logic                 busy,
  output logic                 done
`ifdef SUGAR_LEDGER_OVERRUN_EN
  ,
  output logic [7:0]           overrun_cnt
`endif
);

  localparam int IW = (N_ANTS > 1) ? $clog2(N_ANTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_RD,
    S_WAIT,
    S_WR,
    S_DROP,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]        idx;
  logic [N_ANTS-1:0]    col_q, drp_q;
  logic [N_ANTS*XW-1:0] x_q;
  logic [N_ANTS*YW-1:0] y_q;
  logic [XW+YW-1:0]     addr_q;
  logic [SUGAR_W-1:0]   val_q;

  // Per-cycle strobes from the FSM to the datapath.
  logic snap, load_addr, capture, food_inc, empty_inc, idx_inc;
  logic rd_en, wr_en;
  logic [SUGAR_W-1:0] wdata;

  logic          cur_col, cur_drp, last_ant;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  assign cur_col  = col_q[idx];
  assign cur_drp  = drp_q[idx];
  assign cur_x    = x_q[idx*XW +: XW];
  assign cur_y    = y_q[idx*YW +: YW];
  assign last_ant = (idx == IW'(N_ANTS - 1));

  // Strobes are decoded from state so RESET clears them the same instant
  // it clears the state register; no write can complete after RESET rises.
  assign mem.mem_addr  = addr_q;
  assign mem.mem_rd    = rd_en;
  assign mem.mem_wr    = wr_en;
  assign mem.mem_wdata = wdata;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, independent of process ordering.
  always_ff @(posedge game_clk or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // Next state and per-cycle outputs
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    snap      = 1'b0;
    load_addr = 1'b0;
    capture   = 1'b0;
    food_inc  = 1'b0;
    empty_inc = 1'b0;
    idx_inc   = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wdata     = '0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (update_flag) begin
          snap      = 1'b1;
          state_nxt = S_SCAN;
        end
      end

      S_SCAN: begin
        busy = 1'b1;
        if (cur_col) begin
          load_addr = 1'b1;
          state_nxt = S_RD;
        end else if (cur_drp) begin
          state_nxt = S_DROP;
        end else begin
          idx_inc   = !last_ant;
          state_nxt = last_ant ? S_FIN : S_SCAN;
        end
      end

      S_RD: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        busy      = 1'b1;
        capture   = 1'b1;
        state_nxt = S_WR;
      end

      S_WR: begin
        busy = 1'b1;
        if (val_q != '0) begin
          wr_en = 1'b1;
          wdata = val_q - SUGAR_W'(1);
        end else begin
          empty_inc = 1'b1;
        end
        if (cur_drp) begin
          state_nxt = S_DROP;
        end else begin
          idx_inc   = !last_ant;
          state_nxt = last_ant ? S_FIN : S_SCAN;
        end
      end

      S_DROP: begin
        busy      = 1'b1;
        food_inc  = 1'b1;
        idx_inc   = !last_ant;
        state_nxt = last_ant ? S_FIN : S_SCAN;
      end

      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: snapshot, scan index, address, read capture, tallies
  // ---------------------------------------------------------------------
  // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset
  // along with everything else; the sugar map itself lives outside.
  always_ff @(posedge game_clk or posedge RESET) begin
    if (RESET) begin
      idx         <= '0;
      col_q       <= '0;
      drp_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      val_q       <= '0;
      food_count  <= '0;
      empty_picks <= '0;
    end else begin
      // The snapshot is loaded only from IDLE, so strobes during a scan
      // never disturb the coordinates being walked.
      if (snap) begin
        idx   <= '0;
        col_q <= collect_vec;
        drp_q <= drop_vec;
        x_q   <= ant_X;
        y_q   <= ant_Y;
      end else if (idx_inc) begin
        idx <= idx + IW'(1);
      end

      // Address is registered so it is stable through RD/WAIT/WR and
      // holds its last value while idle.
      if (load_addr) addr_q <= {cur_y, cur_x};
      if (capture)   val_q  <= mem.mem_rdata;

      if (food_inc && (food_count != '1))
        food_count <= food_count + FOOD_W'(1);
      if (empty_inc && (empty_picks != 8'hFF))
        empty_picks <= empty_picks + 8'd1;
    end
  end

`ifdef SUGAR_LEDGER_OVERRUN_EN
  // Any strobe outside IDLE (busy or the FIN cycle) is an overrun.
  always_ff @(posedge game_clk or posedge RESET) begin
    if (RESET)
      overrun_cnt <= '0;
    else if (update_flag && (state != S_IDLE) && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sugar_ledger.sv
// ---------------------------------------------------------------------------
// tb_sugar_ledger
//   Directed bench for sugar_ledger (N_ANTS=8, 4-bit X/Y, 4-bit sugar,
//   FOOD_W=4 so food saturation is reachable). A tick-level model turns
//   each accepted update_flag into the expected RAM operation sequence,
//   scan length and final tallies; a negedge compare process checks the
//   DUT against it every cycle. Hand-computed literals pin the model.
// ---------------------------------------------------------------------------
module tb_sugar_ledger;

  localparam int N_ANTS  = 8;
  localparam int XW      = 4;
  localparam int YW      = 4;
  localparam int SUGAR_W = 4;
  localparam int FOOD_W  = 4;

  logic                 game_clk;
  logic                 RESET;
  logic                 update_flag;
  logic [N_ANTS-1:0]    collect_vec;
  logic [N_ANTS-1:0]    drop_vec;
  logic [N_ANTS*XW-1:0] ant_X;
  logic [N_ANTS*YW-1:0] ant_Y;
  logic [FOOD_W-1:0]    food_count;
  logic [7:0]           empty_picks;
  logic                 busy;
  logic                 done;
`ifdef SUGAR_LEDGER_OVERRUN_EN
  logic [7:0]           overrun_cnt;
`endif

  sugar_ledger_if #(.AW(XW+YW), .DW(SUGAR_W)) mem ();

  sugar_ledger #(
    .N_ANTS(N_ANTS), .XW(XW), .YW(YW), .SUGAR_W(SUGAR_W), .FOOD_W(FOOD_W)
  ) dut (
    .game_clk   (game_clk),
    .RESET      (RESET),
    .update_flag(update_flag),
    .collect_vec(collect_vec),
    .drop_vec   (drop_vec),
    .ant_X      (ant_X),
    .ant_Y      (ant_Y),
    .mem        (mem.master),
    .food_count (food_count),
    .empty_picks(empty_picks),
    .busy       (busy),
    .done       (done)
`ifdef SUGAR_LEDGER_OVERRUN_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  initial game_clk = 1'b0;
  always #5 game_clk = ~game_clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- sugar map RAM (environment) ----------------
  logic [SUGAR_W-1:0] ram [256];
  logic [SUGAR_W-1:0] rd_q;
  int                 wr_cnt = 0;

  assign mem.mem_rdata = rd_q;

  always @(posedge game_clk) begin
    if (mem.mem_wr) begin
      ram[mem.mem_addr] <= mem.mem_wdata;
      wr_cnt            <= wr_cnt + 1;
    end
    if (mem.mem_rd) rd_q <= ram[mem.mem_addr];
  end

  // ---------------- tick-level model ----------------
  typedef struct packed {
    logic       is_wr;
    logic [7:0] addr;
    logic [3:0] data;
  } op_t;

  logic [SUGAR_W-1:0] gmap [256];
  op_t                exp_ops[$];
  bit                 m_active;
  int                 m_cycle, m_cost;
  int                 m_food, m_empty, m_ovr;

  always @(posedge game_clk or posedge RESET) begin
    if (RESET) begin
      m_active = 1'b0;
      m_cycle  = 0;
      m_cost   = 0;
      m_food   = 0;
      m_empty  = 0;
      m_ovr    = 0;
      exp_ops.delete();
    end else if (update_flag && !m_active) begin
      // Apply the whole tick in ant order with plain arithmetic.
      m_cost = N_ANTS + 1;
      for (int i = 0; i < N_ANTS; i++) begin
        logic [7:0] a;
        op_t        op;
        a = {ant_Y[i*YW +: YW], ant_X[i*XW +: XW]};
        if (collect_vec[i]) begin
          m_cost += 3;
          op.is_wr = 1'b0; op.addr = a; op.data = '0;
          exp_ops.push_back(op);
          if (gmap[a] > 0) begin
            gmap[a]  = gmap[a] - 1;
            op.is_wr = 1'b1; op.data = gmap[a];
            exp_ops.push_back(op);
          end else if (m_empty < 255) begin
            m_empty++;
          end
        end
        if (drop_vec[i]) begin
          m_cost += 1;
          if (m_food < (1 << FOOD_W) - 1) m_food++;
        end
      end
      m_active = 1'b1;
      m_cycle  = 1;
    end else begin
      if (update_flag && m_active && m_ovr < 255) m_ovr++;
      if (m_active) begin
        if (m_cycle == m_cost) begin
          m_active = 1'b0;
          m_cycle  = 0;
        end else begin
          m_cycle++;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge game_clk) begin
    if (!RESET) begin
      if (mem.mem_rd && mem.mem_wr) check("rd_wr_overlap", 1, 0);
      if (mem.mem_rd || mem.mem_wr) begin
        if (exp_ops.size() == 0) begin
          check("unexpected_mem_op", {mem.mem_wr, mem.mem_rd}, 0);
        end else begin
          op_t e;
          e = exp_ops.pop_front();
          check("op_kind", mem.mem_wr, e.is_wr);
          check("op_addr", mem.mem_addr, e.addr);
          if (e.is_wr) check("op_wdata", mem.mem_wdata, e.data);
        end
      end
      if (m_active && m_cycle < m_cost) begin
        check("busy_in_scan", busy, 1);
        check("done_in_scan", done, 0);
      end else if (m_active) begin
        check("done_at_fin", done, 1);
        check("busy_at_fin", busy, 0);
        check("ops_left_at_fin", exp_ops.size(), 0);
        check("food_at_fin", food_count, m_food);
        check("empty_at_fin", empty_picks, m_empty);
`ifdef SUGAR_LEDGER_OVERRUN_EN
        check("overrun_at_fin", overrun_cnt, m_ovr);
`endif
      end else begin
        check("busy_idle", busy, 0);
        check("done_idle", done, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic poke(input logic [7:0] a, input logic [SUGAR_W-1:0] v);
    ram[a]  = v;
    gmap[a] = v;
  endtask

  // Strobe one tick; lat counts cycles from the strobe cycle (=1) to done.
  task automatic tick(input logic [7:0] col, input logic [7:0] drp,
                      input logic [31:0] xs, input logic [31:0] ys,
                      output int lat);
    @(posedge game_clk); #1;
    collect_vec = col; drop_vec = drp; ant_X = xs; ant_Y = ys;
    update_flag = 1'b1;
    @(negedge game_clk);
    lat = 1;
    @(posedge game_clk); #1;
    update_flag = 1'b0;
    // Live inputs wander during the scan; only the snapshot may matter.
    collect_vec = ~col; drop_vec = ~drp; ant_X = ~xs; ant_Y = ~ys;
    for (int k = 0; k < 80; k++) begin
      @(negedge game_clk);
      lat++;
      if (done) break;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  // ---------------- directed tests ----------------
  int lat, wr0, n_done;

  initial begin
    RESET = 1'b1; update_flag = 1'b0;
    collect_vec = '0; drop_vec = '0; ant_X = '0; ant_Y = '0;
    rd_q = '0;
    for (int a = 0; a < 256; a++) begin ram[a] = '0; gmap[a] = '0; end
    repeat (3) @(posedge game_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd", mem.mem_rd, 0);
    check("rst_wr", mem.mem_wr, 0);
    check("rst_addr", mem.mem_addr, 0);
    check("rst_food", food_count, 0);
    check("rst_empty", empty_picks, 0);
    @(negedge game_clk); RESET = 1'b0;

    // T1: empty tick; 8 SCAN + FIN, done on the 10th cycle counting the strobe.
    wr0 = wr_cnt;
    tick(8'h00, 8'h00, 32'h0, 32'h0, lat);
    check("t1_latency", lat, 10);
    check("t1_writes", wr_cnt - wr0, 0);
    check("t1_food", food_count, 0);

    // T2: ant 2 collects at X=5,Y=3, cell holds 4 -> written back as 3.
    poke(8'h35, 4'd4);
    tick(8'h04, 8'h00, 32'h0000_0500, 32'h0000_0300, lat);
    check("t2_latency", lat, 13);
    @(posedge game_clk); #1;
    check("t2_cell", ram[8'h35], 3);
    check("t2_empty", empty_picks, 0);

    // T3: ants 0 and 5 on cell {2,1} holding 1 -> one write of 0, one empty pick.
    poke(8'h21, 4'd1);
    wr0 = wr_cnt;
    tick(8'h21, 8'h00, 32'h0010_0001, 32'h0020_0002, lat);
    @(posedge game_clk); #1;
    check("t3_cell", ram[8'h21], 0);
    check("t3_writes", wr_cnt - wr0, 1);
    check("t3_empty", empty_picks, 1);

    // T4: all ants drop; 4-bit food goes 8 -> 15 -> stays 15.
    tick(8'h00, 8'hFF, 32'h0, 32'h0, lat);
    check("t4_food_a", food_count, 8);
    tick(8'h00, 8'hFF, 32'h0, 32'h0, lat);
    check("t4_food_b", food_count, 15);
    tick(8'h00, 8'hFF, 32'h0, 32'h0, lat);
    check("t4_food_c", food_count, 15);

    // T5: second strobe 4 cycles into a scan is ignored.
    poke(8'h44, 4'd2);
    wr0 = wr_cnt;
    @(posedge game_clk); #1;
    collect_vec = 8'h02; drop_vec = 8'h00; ant_X = 32'h0000_0040; ant_Y = 32'h0000_0040;
    update_flag = 1'b1;
    @(posedge game_clk); #1;
    update_flag = 1'b0;
    repeat (3) @(posedge game_clk);
    #1;
    collect_vec = 8'hFF; drop_vec = 8'hFF; ant_X = 32'h1234_5678; ant_Y = 32'h8765_4321;
    update_flag = 1'b1;
    @(posedge game_clk); #1;
    update_flag = 1'b0;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge game_clk);
      if (done) n_done++;
    end
    check("t5_done_count", n_done, 1);
    check("t5_cell", ram[8'h44], 1);
    check("t5_writes", wr_cnt - wr0, 1);
`ifdef SUGAR_LEDGER_OVERRUN_EN
    check("t5_overrun", overrun_cnt, 1);
`endif

    // T6: RESET while the write strobe is high aborts the write.
    poke(8'h10, 4'd5);
    @(posedge game_clk); #1;
    collect_vec = 8'h01; drop_vec = 8'h01; ant_X = 32'h0; ant_Y = 32'h0000_0001;
    update_flag = 1'b1;
    @(posedge game_clk); #1;
    update_flag = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge game_clk);
        seen = mem.mem_wr;
      end
      check("t6_wr_seen", seen, 1);
    end
    #2 RESET = 1'b1;
    #1;
    check("t6_wr_drop", mem.mem_wr, 0);
    check("t6_rd_drop", mem.mem_rd, 0);
    check("t6_busy", busy, 0);
    check("t6_food", food_count, 0);
    check("t6_empty", empty_picks, 0);
    check("t6_addr", mem.mem_addr, 0);
    @(posedge game_clk); #1;
    check("t6_cell_kept", ram[8'h10], 5);
`ifdef SUGAR_LEDGER_OVERRUN_EN
    check("t6_overrun", overrun_cnt, 0);
`endif
    @(negedge game_clk); RESET = 1'b0;
    // The aborted scan left the RAM as it was; model adopts it.
    for (int a = 0; a < 256; a++) gmap[a] = ram[a];
    poke(8'h77, 4'd0);
    tick(8'h81, 8'h00, 32'h7000_0000, 32'h7000_0001, lat);
    @(posedge game_clk); #1;
    check("t6_clean_cell", ram[8'h10], 4);
    check("t6_clean_empty", empty_picks, 1);

    // T7: 33 ticks of 8 empty picks each -> 264 saturates at 255.
    poke(8'hFF, 4'd0);
    for (int t = 0; t < 33; t++)
      tick(8'hFF, 8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("t7_empty_sat", empty_picks, 255);

    repeat (3) @(posedge game_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
